tff_count_seq: RTL and testbench
================================

TFF_COUNT_SEQ -- requirements
Module: tff_count_seq

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 Parameter MAX, default 9, terminal value; the block SHALL require 1 <= MAX <= 2^WIDTH-1.
REQ-003 clk  input  1  single clock; all state SHALL update on the posedge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level; sampled each edge; enters or resumes counting.
REQ-006 stop  input  1  level; sampled each edge; pauses counting and holds the count.
REQ-007 clear  input  1  level; synchronous clear to 0 and IDLE.
REQ-008 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-009 count  output  WIDTH  current count; taken directly from the toggle-cell bank.
REQ-010 busy  output  1  high while the state is RUN.
REQ-011 tc  output  1  combinational; high when state is RUN and count is at terminal (MAX if up_dn=1, 0 if up_dn=0).
REQ-012 done  output  1  one-shot completion flag (see Configuration).

Function
REQ-013 The block SHALL implement the FSM states IDLE, RUN, HOLD and DONE; DONE exists only under REQ-030.
REQ-014 Input priority SHALL be clear > stop > start.
REQ-015 clear=1 at an edge SHALL set count to 0 and the state to IDLE, from any state.
REQ-016 Transitions: IDLE + start -> RUN; RUN + stop -> HOLD; HOLD + start -> RUN; any other combination SHALL hold the current state.
REQ-017 count SHALL change only on an edge where the registered state is RUN and neither clear nor stop is 1 at that edge.
REQ-018 Latency: if start is sampled at edge N from IDLE, count SHALL first change at edge N+1.
REQ-019 Up step: next = count+1, except count >= MAX gives next = 0.
REQ-020 Down step: next = count-1, except count = 0 or count > MAX gives next = MAX.
REQ-021 Each bank bit i SHALL receive toggle enable t[i] = count[i] XOR next[i] when stepping, and 0 otherwise.
REQ-022 A change of up_dn during RUN SHALL take effect on the next step edge, with no skipped or repeated value.
REQ-023 stop and start asserted together in RUN SHALL give HOLD, and count SHALL NOT change.
REQ-024 In IDLE and HOLD, count SHALL hold; tc SHALL be 0.

Reset
REQ-025 rstn=0 SHALL immediately, independent of clk, set count=0, state=IDLE, busy=0, done=0, and tc=0.
REQ-026 Reset asserted mid-RUN SHALL abort the sequence; after release, no count change SHALL occur until start is sampled.
REQ-027 Reset release SHALL be synchronised externally; the block SHALL NOT add a reset synchroniser.

Configuration
REQ-028 Macro TFF_COUNT_SEQ_ONESHOT_EN SHALL select one-shot mode.
REQ-029 Without the macro: the terminal step SHALL wrap per REQ-019/020, counting SHALL continue, and done SHALL be tied to 0.
REQ-030 With the macro, at the terminal step edge:
- count SHALL wrap per REQ-019/020.
- state SHALL go to DONE, with done=1 and busy=0.
- DONE + start SHALL go to RUN and clear done; DONE + clear SHALL go to IDLE and clear done.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, RUN, HOLD, DONE) and the default WIDTH/MAX constants.
REQ-032 The count bank SHALL be WIDTH instances of one sub-module, tog_cell (ports clk, rstn, t, q): an async-reset toggle cell.
REQ-033 The controller SHALL hold only the FSM and the next-value/toggle-enable logic; it SHALL hold no count register.

Verification (WIDTH=4, MAX=9)
REQ-034 Reset, then start=1 at edge 0 with up_dn=1 -> count 1 at edge 1; 9 at edge 9; 0 at edge 10; tc=1 only while count=9.
REQ-035 up_dn=0 from IDLE at count 0, start -> count 9 at the first step, then 8, 7, ...; tc=1 while count=0 in RUN.
REQ-036 At count 5 in RUN, drive stop=1 and start=1 together -> HOLD, count stays 5, busy=0; later start alone -> count 6 on the following edge.
REQ-037 At count 7, pulse clear together with stop -> count 0, IDLE; rstn low mid-cycle at count 3 -> count 0 immediately, with no clk edge needed.
REQ-038 With TFF_COUNT_SEQ_ONESHOT_EN, run up from 0 -> count 0 and done=1 after edge 10, with count holding; start -> done=0 and count 1 on the next step.
REQ-039 Flip up_dn at count 4 (up) -> sequence 4, 5, then 4, 3 on the following steps, with no skip or repeat.

Source files
------------

// File: rtl/tff_count_seq_pkg.sv
// Shared types and default sizing for the toggle-cell sequence counter.
package tff_count_seq_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_MAX   = 9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/tff_count_seq_ctrl.sv
// Sequencer FSM plus next-value / toggle-enable logic. Holds no count
// register: the count lives in the toggle-cell bank and is fed back here.
// Optional one-shot mode: define TFF_COUNT_SEQ_ONESHOT_EN.
//
// state | meaning
// IDLE  | stopped after reset or clear, count held
// RUN   | stepping once per edge in the up_dn direction
// HOLD  | paused by stop, count held, resumes on start
// DONE  | one-shot finished after the wrap step, done high
module tff_count_seq_ctrl
   import tff_count_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int MAX   = DEF_MAX
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             up_dn,
   input  logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] t,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   state_t           state;
   logic             step;
   logic             wrap;
   logic [WIDTH-1:0] nxt;

   // Next value, wrap detection and per-bit toggle enables. A clear is
   // realised by toggling every set bit, which lands the bank on zero.
   always_comb begin
      step = (state == ST_RUN) && !clear && !stop;
      if (up_dn) begin
         wrap = (count >= MAX_V);
         nxt  = wrap ? '0 : count + ONE;
      end else begin
         wrap = (count == '0) || (count > MAX_V);
         nxt  = wrap ? MAX_V : count - ONE;
      end
      if (clear)     t = count;
      else if (step) t = count ^ nxt;
      else           t = '0;
      tc = (state == ST_RUN) && (up_dn ? (count == MAX_V) : (count == '0));
   end

`ifdef TFF_COUNT_SEQ_ONESHOT_EN
   logic done_q;
   assign done = done_q;
`else
   assign done = 1'b0;
`endif

   // Sequencer with registered busy/done; priority clear > stop > start.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= ST_IDLE;
         busy   <= 1'b0;
`ifdef TFF_COUNT_SEQ_ONESHOT_EN
         done_q <= 1'b0;
`endif
      end else if (clear) begin
         state  <= ST_IDLE;
         busy   <= 1'b0;
`ifdef TFF_COUNT_SEQ_ONESHOT_EN
         done_q <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_HOLD: begin
               if (!stop && start) begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state <= ST_HOLD;
                  busy  <= 1'b0;
               end
`ifdef TFF_COUNT_SEQ_ONESHOT_EN
               else if (wrap) begin
                  state  <= ST_DONE;
                  busy   <= 1'b0;
                  done_q <= 1'b1;
               end
`endif
            end
            ST_DONE: begin
               if (!stop && start) begin
                  state  <= ST_RUN;
                  busy   <= 1'b1;
`ifdef TFF_COUNT_SEQ_ONESHOT_EN
                  done_q <= 1'b0;
`endif
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/tff_count_seq_tog_cell.sv
// Single T flip-flop with asynchronous active-low reset; one per count bit.
module tog_cell (
   input  logic clk,
   input  logic rstn,
   input  logic t,
   output logic q
);

   // Flip q on every edge where t is high.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) q <= 1'b0;
      else if (t) q <= ~q;
   end

endmodule

// File: rtl/tff_count_seq.sv
// Start/stop/clear up-down counter built from a bank of toggle cells.
// Optional one-shot mode: define TFF_COUNT_SEQ_ONESHOT_EN.
module tff_count_seq
   import tff_count_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int MAX   = DEF_MAX
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             up_dn,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   if (MAX < 1 || MAX > (2**WIDTH) - 1) begin : g_bad_max
      $error("tff_count_seq: MAX out of range for WIDTH");
   end

   logic [WIDTH-1:0] t;

   tff_count_seq_ctrl #(
      .WIDTH (WIDTH),
      .MAX   (MAX)
   ) u_ctrl (
      .clk   (clk),
      .rstn  (rstn),
      .start (start),
      .stop  (stop),
      .clear (clear),
      .up_dn (up_dn),
      .count (count),
      .t     (t),
      .busy  (busy),
      .tc    (tc),
      .done  (done)
   );

   for (genvar i = 0; i < WIDTH; i++) begin : g_bank
      tog_cell u_cell (
         .clk  (clk),
         .rstn (rstn),
         .t    (t[i]),
         .q    (count[i])
      );
   end

endmodule

// File: tb/tb_tff_count_seq.sv
// Self-checking bench for tff_count_seq (WIDTH=4, MAX=9): vector table,
// hand-written corner sequences and a randomized run against a model.
module tb_tff_count_seq;

   localparam int WIDTH = 4;
   localparam int MAX   = 9;
`ifdef TFF_COUNT_SEQ_ONESHOT_EN
   localparam bit ONESHOT = 1'b1;
`else
   localparam bit ONESHOT = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             start = 1'b0, stop = 1'b0, clear = 1'b0, up_dn = 1'b1;
   logic [WIDTH-1:0] count;
   logic             busy, tc, done;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: mode 0 idle, 1 counting, 2 paused, 3 finished
   int m_mode = 0;
   int m_cnt  = 0;
   bit m_done = 0;

   tff_count_seq #(.WIDTH(WIDTH), .MAX(MAX)) dut (
      .clk(clk), .rstn(rstn), .start(start), .stop(stop), .clear(clear),
      .up_dn(up_dn), .count(count), .busy(busy), .tc(tc), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit st, sp, cl, ud;
      int exp_cnt;
      bit exp_busy, exp_tc;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_cnt  = 0;
      m_done = 0;
   endtask

   task automatic model_edge(input bit st, sp, cl, ud);
      bit term;
      if (cl) begin
         m_mode = 0; m_cnt = 0; m_done = 0;
      end else if (m_mode == 1) begin
         if (sp) m_mode = 2;
         else begin
            term  = ud ? (m_cnt >= MAX) : (m_cnt == 0);
            m_cnt = ud ? (term ? 0 : m_cnt + 1) : (term ? MAX : m_cnt - 1);
            if (ONESHOT && term) begin
               m_mode = 3; m_done = 1;
            end
         end
      end else if (!sp && st) begin
         m_mode = 1; m_done = 0;
      end
   endtask

   task automatic chk_model(input string tag);
      bit m_tc;
      m_tc = (m_mode == 1) && (up_dn ? (m_cnt == MAX) : (m_cnt == 0));
      chk({tag, ".count"}, int'(count), m_cnt);
      chk({tag, ".busy"},  int'(busy),  int'(m_mode == 1));
      chk({tag, ".tc"},    int'(tc),    int'(m_tc));
      chk({tag, ".done"},  int'(done),  int'(m_done));
   endtask

   // drive inputs, take one edge, update model, sample #1 later
   task automatic cyc(input bit st, sp, cl, ud, input string tag);
      start = st; stop = sp; clear = cl; up_dn = ud;
      @(posedge clk);
      model_edge(st, sp, cl, ud);
      #1;
      chk_model(tag);
   endtask

   task automatic do_reset();
      #2;
      rstn = 1'b0;
      model_reset();
      #1;
      chk_model("reset");
      #2;
      rstn = 1'b1;
   endtask

   vec_t vecs[10];

   initial begin
      // edges 0..9 of an up run from reset
      for (int i = 0; i < 10; i++)
         vecs[i] = '{st: 1'b1, sp: 1'b0, cl: 1'b0, ud: 1'b1,
                     exp_cnt: i, exp_busy: 1'b1, exp_tc: (i == 9)};

      #3;
      model_reset();
      chk_model("por");
      chk("por.count_const", int'(count), 0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // up sequence from reset
      for (int i = 0; i < 10; i++) begin
         start = vecs[i].st; stop = vecs[i].sp; clear = vecs[i].cl; up_dn = vecs[i].ud;
         @(posedge clk);
         model_edge(vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].ud);
         #1;
         chk($sformatf("vec%0d.count", i), int'(count), vecs[i].exp_cnt);
         chk($sformatf("vec%0d.busy", i),  int'(busy),  int'(vecs[i].exp_busy));
         chk($sformatf("vec%0d.tc", i),    int'(tc),    int'(vecs[i].exp_tc));
      end
      cyc(1, 0, 0, 1, "edge10");
      chk("edge10.count_const", int'(count), 0);
`ifdef TFF_COUNT_SEQ_ONESHOT_EN
      chk("oneshot.done", int'(done), 1);
      chk("oneshot.busy", int'(busy), 0);
      cyc(0, 0, 0, 1, "oneshot.hold1");
      cyc(0, 0, 0, 1, "oneshot.hold2");
      chk("oneshot.hold_count", int'(count), 0);
      cyc(1, 0, 0, 1, "oneshot.restart");
      chk("oneshot.restart_done", int'(done), 0);
      cyc(0, 0, 0, 1, "oneshot.step1");
      chk("oneshot.step1_count", int'(count), 1);
`else
      chk("wrap.busy", int'(busy), 1);
      cyc(1, 0, 0, 1, "edge11");
      chk("edge11.count_const", int'(count), 1);
`endif

      // down run from IDLE at 0
      cyc(0, 0, 1, 0, "dn.clear");
      cyc(1, 0, 0, 0, "dn.start");
      chk("dn.tc_at0", int'(tc), 1);
      cyc(0, 0, 0, 0, "dn.s1");
      chk("dn.s1_count", int'(count), 9);
`ifndef TFF_COUNT_SEQ_ONESHOT_EN
      cyc(0, 0, 0, 0, "dn.s2");
      chk("dn.s2_count", int'(count), 8);
      cyc(0, 0, 0, 0, "dn.s3");
      chk("dn.s3_count", int'(count), 7);
`endif

      // stop+start together at 5, then resume
      cyc(0, 0, 1, 1, "hold.clear");
      cyc(1, 0, 0, 1, "hold.start");
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, "hold.run");
      chk("hold.at5", int'(count), 5);
      cyc(1, 1, 0, 1, "hold.stopstart");
      chk("hold.count5", int'(count), 5);
      chk("hold.busy0", int'(busy), 0);
      cyc(0, 0, 0, 1, "hold.idle1");
      cyc(1, 0, 0, 1, "hold.resume");
      chk("hold.resume_count", int'(count), 5);
      cyc(0, 0, 0, 1, "hold.step");
      chk("hold.count6", int'(count), 6);

      // clear with stop at 7
      cyc(0, 0, 0, 1, "clr.run");
      chk("clr.at7", int'(count), 7);
      cyc(0, 1, 1, 1, "clr.clearstop");
      chk("clr.count0", int'(count), 0);
      chk("clr.busy0", int'(busy), 0);

      // async reset mid-cycle at count 3
      cyc(1, 0, 0, 1, "ar.start");
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, "ar.run");
      chk("ar.at3", int'(count), 3);
      do_reset();
      chk("ar.count0", int'(count), 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, "ar.noauto");

      // direction flip at 4
      cyc(1, 0, 0, 1, "flip.start");
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, "flip.up");
      chk("flip.at4", int'(count), 4);
      cyc(0, 0, 0, 1, "flip.up5");
      chk("flip.count5", int'(count), 5);
      cyc(0, 0, 0, 0, "flip.dn4");
      chk("flip.count4", int'(count), 4);
      cyc(0, 0, 0, 0, "flip.dn3");
      chk("flip.count3", int'(count), 3);

      // randomized run against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            cyc(($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 4) != 0),
                "rnd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
